// File: rtl/main_mem_responder_if.sv
// rtl/main_mem_responder_if.sv - memory request/response bus between arbiter and main memory
interface main_mem_responder_if #(
    parameter int ADDR_BITS = 28,
    parameter int DATA_BITS = 128,
    parameter int TAG_BITS  = 5
);
    logic                   mem_req_valid;
    logic                   mem_req_ready;
    logic                   mem_req_rw;
    logic [ADDR_BITS-1:0]   mem_req_addr;
    logic [TAG_BITS-1:0]    mem_req_tag;
    logic                   mem_req_data_valid;
    logic                   mem_req_data_ready;
    logic [DATA_BITS-1:0]   mem_req_data_bits;
    logic [DATA_BITS/8-1:0] mem_req_data_mask;
    logic                   mem_resp_valid;
    logic [DATA_BITS-1:0]   mem_resp_data;
    logic [TAG_BITS-1:0]    mem_resp_tag;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_ready, mem_req_data_ready,
        input  mem_resp_valid, mem_resp_data, mem_resp_tag
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_ready, mem_req_data_ready,
        output mem_resp_valid, mem_resp_data, mem_resp_tag
    );
endinterface

// File: rtl/main_mem_responder.sv
// rtl/main_mem_responder.sv - in-order line-based main memory model with fixed read latency
module main_mem_responder #(
    parameter int ADDR_BITS    = 28,
    parameter int DATA_BITS    = 128,
    parameter int TAG_BITS     = 5,
    parameter int DATA_CYCLES  = 4,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 4
) (
    input  logic              clk,
    input  logic              reset,
    main_mem_responder_if.slave mem
);
    localparam int BW     = (DATA_CYCLES > 1) ? $clog2(DATA_CYCLES) : 1;
    localparam int LW     = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int NBYTES = DATA_BITS / 8;
    localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'(DATA_CYCLES - 1);
    localparam logic [BW-1:0]        LAST_BEAT = BW'(DATA_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WDATA, RWAIT, RBURST} state_t;

    state_t                state;
    logic [BW-1:0]         beat;
    logic [LW-1:0]         lat;
    logic [ADDR_BITS-1:0]  base;
    logic [TAG_BITS-1:0]   tag_q;
    logic [DATA_BITS-1:0]  storage [2**DEPTH_LOG2];
    logic [DATA_BITS-1:0]  rd_q;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;
    logic                  wr_en;
    logic                  resp_on;

    // Handshake outputs are decoded from registered state and forced low while reset is held.
    assign mem.mem_req_ready      = (state == IDLE)  && !reset;
    assign mem.mem_req_data_ready = (state == WDATA) && !reset;
    assign resp_on                = (state == RBURST) && !reset;
    assign mem.mem_resp_valid     = resp_on;
    assign mem.mem_resp_data      = resp_on ? rd_q  : '0;
    assign mem.mem_resp_tag       = resp_on ? tag_q : '0;

    assign wr_en  = mem.mem_req_data_valid && mem.mem_req_data_ready;
    assign wr_idx = DEPTH_LOG2'(base + ADDR_BITS'(beat));

    // Prefetch address: the beat that will be presented in the following cycle.
    always_comb begin
        rd_idx = DEPTH_LOG2'(base);
        case (state)
            IDLE:    rd_idx = DEPTH_LOG2'(mem.mem_req_addr & LINE_MASK);
            RBURST:  rd_idx = DEPTH_LOG2'(base + ADDR_BITS'(beat) + ADDR_BITS'(1));
            default: rd_idx = DEPTH_LOG2'(base);
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (mem.mem_req_data_mask[b]) begin
                    storage[wr_idx][8*b +: 8] <= mem.mem_req_data_bits[8*b +: 8];
                end
            end
        end
        rd_q <= storage[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            lat   <= '0;
            base  <= '0;
            tag_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem.mem_req_valid) begin
                        base  <= mem.mem_req_addr & LINE_MASK;
                        tag_q <= mem.mem_req_tag;
                        beat  <= '0;
                        if (mem.mem_req_rw) begin
                            state <= WDATA;
                        end else if (READ_LATENCY == 1) begin
                            state <= RBURST;
                        end else begin
                            lat   <= LW'(READ_LATENCY - 1);
                            state <= RWAIT;
                        end
                    end
                end
                WDATA: begin
                    if (mem.mem_req_data_valid) begin
                        beat <= beat + BW'(1);
                        if (beat == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                RWAIT: begin
                    lat <= lat - LW'(1);
                    if (lat == LW'(1)) begin
                        state <= RBURST;
                    end
                end
                RBURST: begin
                    beat <= beat + BW'(1);
                    if (beat == LAST_BEAT) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/main_mem_responder.md
Name: main_mem_responder

Overview:
Synthesizable main-memory model that responds to the cache/arbiter memory request interface. It accepts read and write line requests, absorbs write data beats with byte masks, and returns tagged read bursts after a fixed latency. It sits below the arbiter in simulation and FPGA builds, replacing external DRAM. It serves one request at a time, in order.

Parameters:
ADDR_BITS, 28, request address width in DATA_BITS-wide beats (matches `MEM_ADDR_BITS)
DATA_BITS, 128, beat width (matches `MEM_DATA_BITS)
TAG_BITS, 5, tag width (matches `MEM_TAG_BITS)
DATA_CYCLES, 4, beats per line, power of two
DEPTH_LOG2, 12, log2 of storage depth in beats
READ_LATENCY, 4, cycles from read accept to first response beat, >=1

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous active-high reset
mem_req_valid  in  1  request valid
mem_req_ready  out  1  responder can accept a request
mem_req_rw  in  1  1=write, 0=read
mem_req_addr  in  ADDR_BITS  beat address; low log2(DATA_CYCLES) bits ignored
mem_req_tag  in  TAG_BITS  request tag, echoed on read response
mem_req_data_valid  in  1  write data beat valid
mem_req_data_ready  out  1  responder accepts write data beat
mem_req_data_bits  in  DATA_BITS  write data beat
mem_req_data_mask  in  DATA_BITS/8  byte enables; bit i -> bits [8i+7:8i]
mem_resp_valid  out  1  read response beat valid; no backpressure
mem_resp_data  out  DATA_BITS  read response beat
mem_resp_tag  out  TAG_BITS  tag of the read being returned

Behaviour:
- Reset (sync, high): state=IDLE, beat counter=0, latency counter=0. While reset is high, mem_req_ready=0, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_data=0 and mem_resp_tag=0. Storage contents are not cleared.
- Reset mid-operation aborts immediately. No further response beats are issued. Write beats already accepted stay in storage.
- Line base = {addr[ADDR_BITS-1:log2 DC], 0}. Beat i uses base+i. Storage index = low DEPTH_LOG2 bits of the beat address, so higher bits alias.
- FSM states: IDLE, WDATA, RWAIT, RBURST.
- IDLE:
  - mem_req_ready=1.
  - On valid&ready, latch base and tag, then clear the beat counter.
  - rw=1 -> WDATA. rw=0 -> RWAIT with latency counter=READ_LATENCY-1, or directly to RBURST if READ_LATENCY=1.
- WDATA:
  - mem_req_ready=0, mem_req_data_ready=1.
  - Each data_valid&data_ready writes the masked bytes to base+counter, then increments the counter. Bubbles are allowed.
  - After the DATA_CYCLES-th beat, go to IDLE; ready is 1 the next cycle.
  - Writes produce no response.
- data_valid outside WDATA is ignored (data_ready=0).
- RWAIT: decrement the latency counter; at 0, go to RBURST.
- RBURST:
  - mem_resp_valid=1 for exactly DATA_CYCLES consecutive cycles.
  - Beat i carries storage[base+i], with mem_resp_tag=latched tag on every beat.
  - Go to IDLE after the last beat.
- Timing: a read accepted at edge T has its first mem_resp_valid beat in cycle T+READ_LATENCY and its last in T+READ_LATENCY+DATA_CYCLES-1.
- Read data uses a registered (sync) storage read, prefetched one cycle ahead. mem_resp_data=0 when resp_valid=0.
- mem_req_ready=0 in WDATA, RWAIT and RBURST. A held request is accepted in the first IDLE cycle after the previous transaction.
- A read after a completed write to the same line returns the written data.

Test Plan:
- Reset: reset=1 for 2 cycles with mem_req_valid=1 -> ready=0, resp_valid=0, data_ready=0 during reset; ready=1 in the first cycle after deassert; no request is accepted during reset.
- Write/read: write addr 0x10 tag 3 with beats 0xA0..0xA3, mask 16'hFFFF; then read addr 0x12 tag 7 accepted at T -> resp_valid in cycles T+4..T+7 with data 0xA0,0xA1,0xA2,0xA3 and tag 7 on each beat.
- Partial mask: write addr 0x10 with beat0=all ones, mask 16'h000F, and beats 1..3 with mask 0 -> read returns beat0 with bits [31:0]=FFFFFFFF and bits [127:32] equal to the 0xA0 upper bits; beats 1..3 unchanged.
- Flow control: write data_valid pattern 1,0,1,1,0,1 -> exactly 4 beats written, IDLE after the 6th cycle. A read request held during the prior burst is accepted the cycle after the last response beat.
- Reset mid-burst: assert reset after 2 response beats -> no third beat; after reset, re-reading 0x10 returns the full line.
- Aliasing: read addr 0x10 | (1<<12) -> same data as addr 0x10.
